// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing constants, glyph block size and position limits.
// Pure declarations: no logic, no latency, no backpressure.
// The position word layout is shared by the controller and the renderer.
package vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int H_TOTAL      = 800;

  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;
  localparam int V_TOTAL      = 525;

  localparam int OBJ_W = 141;
  localparam int OBJ_H = 40;

  // Largest top-left coordinate that keeps the block inside the active area.
  function automatic int axis_max(input int active, input int obj);
    return active - obj;
  endfunction

  localparam int XMAX = axis_max(H_ACTIVE, OBJ_W);
  localparam int YMAX = axis_max(V_ACTIVE, OBJ_H);

  typedef struct packed {
    logic [15:0] y;
    logic [15:0] x;
  } center_t;

endpackage

// File: rtl/vga_bounce_axis.sv
// One bounce axis: position register plus direction bit, clamped at 0 and MAX.
// Latency: position updates on the clock after load_en or step_en.
// No backpressure: load_en wins over step_en; both are single-cycle strobes.
module vga_bounce_axis #(
  parameter int MAX       = 499,
  parameter int STEP      = 1,
  parameter int RESET_POS = 0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        step_en,
  input  logic        load_en,
  input  logic [15:0] load_pos,
  output logic [15:0] pos
);

  localparam logic [16:0] MAX17  = 17'(MAX);
  localparam logic [16:0] STEP17 = 17'(STEP);
  localparam logic [15:0] MAX16  = 16'(MAX);
  localparam logic [15:0] STEP16 = 16'(STEP);

  logic        dir_neg;
  logic [16:0] pos_ext;
  logic [16:0] sum;
  logic [15:0] nxt_pos;
  logic        nxt_dir;

  // 17-bit arithmetic so a step past 0xFFFF can never wrap back into range.
  always_comb begin
    pos_ext = {1'b0, pos};
    sum     = pos_ext + STEP17;
    nxt_pos = pos;
    nxt_dir = dir_neg;
    if (!dir_neg) begin
      if (sum >= MAX17) begin
        nxt_pos = MAX16;
        nxt_dir = 1'b1;
      end else begin
        nxt_pos = sum[15:0];
      end
    end else begin
      if (pos_ext <= STEP17) begin
        nxt_pos = 16'd0;
        nxt_dir = 1'b0;
      end else begin
        nxt_pos = pos - STEP16;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      pos     <= 16'(RESET_POS);
      dir_neg <= 1'b0;
    end else if (load_en) begin
      pos <= load_pos;
    end else if (step_en) begin
      pos     <= nxt_pos;
      dir_neg <= nxt_dir;
    end
  end

endmodule

// File: rtl/vga_center_ctrl.sv
// Frame-synchronous glyph position controller: held request or auto-bounce.
// Latency: center/update change one cycle after the vsync falling edge.
// Backpressure: req_ready low while a request is pending until the next tick.
module vga_center_ctrl #(
  parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE  = vga_pkg::V_ACTIVE,
  parameter int OBJ_W     = vga_pkg::OBJ_W,
  parameter int OBJ_H     = vga_pkg::OBJ_H,
  parameter int STEP_X    = 1,
  parameter int STEP_Y    = 1,
  parameter int FRAME_DIV = 1,
  parameter int RESET_X   = 0,
  parameter int RESET_Y   = 0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vga_vs,
  input  logic        auto_en,
  input  logic        req_valid,
  input  logic [31:0] req_center,
  output logic        req_ready,
  output logic [31:0] center,
  output logic        update
);

  import vga_pkg::*;

  localparam int          X_LIMIT  = axis_max(H_ACTIVE, OBJ_W);
  localparam int          Y_LIMIT  = axis_max(V_ACTIVE, OBJ_H);
  localparam logic [15:0] X_LIM16  = 16'(X_LIMIT);
  localparam logic [15:0] Y_LIM16  = 16'(Y_LIMIT);
  localparam logic [15:0] DIV_LAST = 16'(FRAME_DIV - 1);

  center_t     req_c;
  center_t     pend_c;
  logic        pend_valid;
  logic        vs_q;
  logic        tick;
  logic        accept;
  logic        load_en;
  logic        step_en;
  logic        div_hit;
  logic [15:0] div_cnt;
  logic [15:0] x_pos;
  logic [15:0] y_pos;
  logic [15:0] clamp_x;
  logic [15:0] clamp_y;

  assign req_c     = req_center;
  assign tick      = vs_q & ~vga_vs;
  assign req_ready = ~rst & ~pend_valid;
  assign accept    = req_valid & req_ready;
  assign clamp_x   = (req_c.x > X_LIM16) ? X_LIM16 : req_c.x;
  assign clamp_y   = (req_c.y > Y_LIM16) ? Y_LIM16 : req_c.y;

  // A pending request always beats auto motion at the same tick.
  assign div_hit = (div_cnt == DIV_LAST);
  assign load_en = tick & pend_valid;
  assign step_en = tick & ~pend_valid & auto_en & div_hit;

  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_q       <= 1'b0;
      pend_valid <= 1'b0;
      pend_c     <= '0;
      div_cnt    <= 16'd0;
      update     <= 1'b0;
    end else begin
      vs_q   <= vga_vs;
      update <= load_en | step_en;
      if (load_en) begin
        pend_valid <= 1'b0;
      end else if (accept) begin
        pend_valid <= 1'b1;
      end
      if (accept) begin
        pend_c.x <= clamp_x;
        pend_c.y <= clamp_y;
      end
      if (tick) begin
        if (pend_valid || !auto_en || div_hit) begin
          div_cnt <= 16'd0;
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
      end
    end
  end

  vga_bounce_axis #(
    .MAX       (X_LIMIT),
    .STEP      (STEP_X),
    .RESET_POS (RESET_X)
  ) u_axis_x (
    .pclk     (pclk),
    .rst      (rst),
    .step_en  (step_en),
    .load_en  (load_en),
    .load_pos (pend_c.x),
    .pos      (x_pos)
  );

  vga_bounce_axis #(
    .MAX       (Y_LIMIT),
    .STEP      (STEP_Y),
    .RESET_POS (RESET_Y)
  ) u_axis_y (
    .pclk     (pclk),
    .rst      (rst),
    .step_en  (step_en),
    .load_en  (load_en),
    .load_pos (pend_c.y),
    .pos      (y_pos)
  );

  assign center = {y_pos, x_pos};

endmodule

// File: tb/tb_vga_center_ctrl.sv
// Scoreboard bench for vga_center_ctrl: dut0 uses defaults, dut1 uses
// STEP_X=4 and FRAME_DIV=3. Expected positions are pushed at each sync edge.
module tb_vga_center_ctrl;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        rst0, vs0, auto0, rv0, rr0, u0;
  logic [31:0] rc0, c0;
  logic        rst1, vs1, auto1, rv1, rr1, u1;
  logic [31:0] rc1, c1;

  vga_center_ctrl dut0 (
    .pclk(pclk), .rst(rst0), .vga_vs(vs0), .auto_en(auto0),
    .req_valid(rv0), .req_center(rc0), .req_ready(rr0),
    .center(c0), .update(u0)
  );

  vga_center_ctrl #(.STEP_X(4), .FRAME_DIV(3)) dut1 (
    .pclk(pclk), .rst(rst1), .vga_vs(vs1), .auto_en(auto1),
    .req_valid(rv1), .req_center(rc1), .req_ready(rr1),
    .center(c1), .update(u1)
  );

  typedef struct {
    logic [31:0] c;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   cyc = 0;
  int   ucnt0 = 0;
  int   ucnt1 = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
  endtask

  // Monitors: every update pulse must match the oldest expected entry.
  always @(negedge pclk) begin
    if (u0 === 1'b1) begin
      ucnt0++;
      if (q0.size() == 0) check("d0_unexpected_update", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        check("d0_center", c0, e0.c);
        check("d0_update_cycle", cyc, e0.due);
      end
    end
  end

  always @(negedge pclk) begin
    if (u1 === 1'b1) begin
      ucnt1++;
      if (q1.size() == 0) check("d1_unexpected_update", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("d1_center", c1, e1.c);
        check("d1_update_cycle", cyc, e1.due);
      end
    end
  end

  task automatic drv_vs(input int d, input logic v);
    if (d == 0) vs0 = v; else vs1 = v;
  endtask

  task automatic drv_req(input int d, input logic v, input logic [31:0] val);
    if (d == 0) begin rv0 = v; rc0 = val; end
    else begin rv1 = v; rc1 = val; end
  endtask

  function automatic logic [31:0] get_c(input int d);
    return (d == 0) ? c0 : c1;
  endfunction

  function automatic logic get_rr(input int d);
    return (d == 0) ? rr0 : rr1;
  endfunction

  function automatic int get_ucnt(input int d);
    return (d == 0) ? ucnt0 : ucnt1;
  endfunction

  // One frame: vsync high, then falling edge; optional request in the tick cycle.
  task automatic frame_tick(input int d, input bit exp_upd, input logic [31:0] exp_c,
                            input bit with_req, input logic [31:0] rq);
    exp_t e;
    @(posedge pclk); #1;
    drv_vs(d, 1'b1);
    repeat (3) @(posedge pclk);
    #1;
    drv_vs(d, 1'b0);
    if (with_req) drv_req(d, 1'b1, rq);
    if (exp_upd) begin
      e.c   = exp_c;
      e.due = cyc + 1;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge pclk); #1;
    if (with_req) drv_req(d, 1'b0, 32'd0);
    repeat (3) @(posedge pclk);
    #1;
  endtask

  task automatic send_req(input int d, input logic [31:0] val);
    @(posedge pclk); #1;
    drv_req(d, 1'b1, val);
    @(posedge pclk); #1;
    drv_req(d, 1'b0, 32'd0);
    check($sformatf("d%0d_req_ready_drop", d), {31'd0, get_rr(d)}, 32'd0);
  endtask

  initial begin
    rst0 = 1'b1; vs0 = 1'b0; auto0 = 1'b0; rv0 = 1'b1; rc0 = 32'h0005_0005;
    rst1 = 1'b1; vs1 = 1'b0; auto1 = 1'b0; rv1 = 1'b0; rc1 = 32'd0;

    // Reset with vsync low and a request offered that must not be taken.
    repeat (3) begin
      @(posedge pclk); #1;
      check("d0_rst_center", c0, 32'd0);
      check("d0_rst_update", {31'd0, u0}, 32'd0);
      check("d0_rst_ready", {31'd0, rr0}, 32'd0);
    end
    rv0 = 1'b0; rc0 = 32'd0;
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    check("d0_ready_after_rst", {31'd0, rr0}, 32'd1);
    repeat (5) @(posedge pclk);
    #1;
    check("d0_center_after_rst", c0, 32'd0);
    check("d0_no_tick_low_vs", ucnt0, 0);
    check("d0_no_pending_after_rst", {31'd0, rr0}, 32'd1);

    // Auto bounce, default steps.
    auto0 = 1'b1;
    frame_tick(0, 1, 32'h0001_0001, 0, 0);
    frame_tick(0, 1, 32'h0002_0002, 0, 0);
    frame_tick(0, 1, 32'h0003_0003, 0, 0);
    check("d0_auto_center", c0, 32'h0003_0003);
    check("d0_auto_count", ucnt0, 3);

    // Request clamp (x=700 -> 499) and deferral to the next tick.
    auto0 = 1'b0;
    @(posedge pclk); #1;
    rv0 = 1'b1; rc0 = 32'h0064_02BC;
    @(posedge pclk); #1;
    check("d0_ready_after_accept", {31'd0, rr0}, 32'd0);
    rc0 = 32'h0001_0001;
    repeat (3) @(posedge pclk);
    #1;
    rv0 = 1'b0; rc0 = 32'd0;
    check("d0_center_deferred", c0, 32'h0003_0003);
    check("d0_ready_while_pending", {31'd0, rr0}, 32'd0);
    frame_tick(0, 1, 32'h0064_01F3, 0, 0);
    check("d0_ready_after_load", {31'd0, rr0}, 32'd1);
    frame_tick(0, 0, 32'd0, 0, 0);
    check("d0_second_req_ignored", c0, 32'h0064_01F3);
    check("d0_hold_count", ucnt0, 4);

    // Reset mid-operation discards the pending request.
    send_req(0, 32'h0010_0010);
    @(posedge pclk); #1;
    rst0 = 1'b1;
    @(posedge pclk); #1;
    rst0 = 1'b0;
    #1;
    check("d0_midrst_center", c0, 32'd0);
    check("d0_midrst_ready", {31'd0, rr0}, 32'd1);
    frame_tick(0, 0, 32'd0, 0, 0);
    check("d0_midrst_hold", c0, 32'd0);
    check("d0_midrst_count", ucnt0, 4);
    check("d0_queue_drained", q0.size(), 0);

    // dut1: right-edge clamp with STEP_X=4, moves every 3rd tick.
    send_req(1, 32'h0000_01F1);
    frame_tick(1, 1, 32'h0000_01F1, 0, 0);
    auto1 = 1'b1;
    frame_tick(1, 0, 32'd0, 0, 0);
    frame_tick(1, 0, 32'd0, 0, 0);
    frame_tick(1, 1, 32'h0001_01F3, 0, 0);
    frame_tick(1, 0, 32'd0, 0, 0);
    frame_tick(1, 0, 32'd0, 0, 0);
    frame_tick(1, 1, 32'h0002_01EF, 0, 0);
    frame_tick(1, 0, 32'd0, 0, 0);
    frame_tick(1, 0, 32'd0, 0, 0);
    frame_tick(1, 1, 32'h0003_01EB, 0, 0);
    check("d1_bounce_count", ucnt1, 4);

    // Request accepted in the tick cycle waits for the following tick.
    auto1 = 1'b0;
    frame_tick(1, 0, 32'd0, 1, 32'h0010_0020);
    check("d1_same_cycle_hold", c1, 32'h0003_01EB);
    check("d1_same_cycle_pending", {31'd0, rr1}, 32'd0);
    check("d1_same_cycle_count", get_ucnt(1), 4);
    frame_tick(1, 1, 32'h0010_0020, 0, 0);
    check("d1_ready_after_load", {31'd0, rr1}, 32'd1);

    // Directions survive the load: x keeps moving down, y up.
    auto1 = 1'b1;
    frame_tick(1, 0, 32'd0, 0, 0);
    frame_tick(1, 0, 32'd0, 0, 0);
    frame_tick(1, 1, 32'h0011_001C, 0, 0);
    check("d1_dir_persist", get_c(1), 32'h0011_001C);
    check("d1_queue_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
